// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared state encoding, widths and saturating increment for the stream arbiter
package stream_arb_pkg;
   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DROP, S_GAP} state_t;
   localparam int STAT_W = 16;
   localparam int DATA_W = 8;
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after the pointer
module rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);
   localparam logic [N-1:0] ONE = 1;
   int idx;
   // scan from lowest to highest priority so the highest-priority request wins last
   always_comb begin
      grant = '0;
      idx   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) grant = ONE << idx;
      end
   end
endmodule

// File: rtl/stream_tx_arbiter.sv
// stream_tx_arbiter: packet-atomic round-robin arbiter onto one 8-bit stream with truncation, gap and stats
module stream_tx_arbiter
   import stream_arb_pkg::*;
#(
   parameter int G_N_PORTS = 2,
   parameter int G_MAX_LEN = 256,
   parameter int G_IFG     = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic [DATA_W*G_N_PORTS-1:0]   s_tdata_in,
   input  logic [G_N_PORTS-1:0]          s_tvalid_in,
   input  logic [G_N_PORTS-1:0]          s_tlast_in,
   output logic [G_N_PORTS-1:0]          s_tready_out,
   output logic [DATA_W-1:0]             m_tdata_out,
   output logic                          m_tvalid_out,
   output logic                          m_tlast_out,
   input  logic                          m_tready_in,
   output logic [G_N_PORTS-1:0]          grant_out,
   output logic [STAT_W*G_N_PORTS-1:0]   stat_pkt_cnt,
   output logic [STAT_W-1:0]             stat_trunc_cnt
);
   localparam int PTR_W = $clog2(G_N_PORTS);
   localparam int BEAT_W = $clog2(G_MAX_LEN);
   localparam logic [3:0] GAP_LAST = 4'((G_IFG == 0) ? 0 : G_IFG - 1);
   localparam state_t DONE_ST = (G_IFG == 0) ? S_IDLE : S_GAP;
   state_t state;
   logic [G_N_PORTS-1:0] rr_grant;
   logic [PTR_W-1:0] ptr, gidx, nxt_ptr;
   logic [BEAT_W-1:0] beat_cnt;
   logic [3:0] gap_cnt;
   logic [STAT_W-1:0] pkt_cnt [G_N_PORTS];
   logic [DATA_W-1:0] sel_data;
   logic out_free, acc, sel_last, last_beat, pkt_inc;
   rr_arbiter #(.N(G_N_PORTS), .PTR_W(PTR_W)) u_rr (
      .req   (s_tvalid_in),
      .ptr   (ptr),
      .grant (rr_grant)
   );
   assign out_free = (state == S_DROP) | ~m_tvalid_out | m_tready_in;
   assign s_tready_out = ((state == S_XFER || state == S_DROP) && out_free) ? grant_out : '0;
   assign acc = |(s_tvalid_in & s_tready_out);
   assign sel_data = s_tdata_in[{gidx, 3'b000} +: DATA_W];
   assign sel_last = s_tlast_in[gidx];
   assign last_beat = beat_cnt == BEAT_W'(G_MAX_LEN - 1);
   assign nxt_ptr = (gidx == PTR_W'(G_N_PORTS - 1)) ? '0 : gidx + 1'b1;
   assign pkt_inc = (state == S_XFER) && acc && (sel_last || last_beat);
   // index of the granted port, used to steer the data/last mux
   always_comb begin
      gidx = '0;
      for (int i = 0; i < G_N_PORTS; i++) if (grant_out[i]) gidx = PTR_W'(i);
   end
   // output register: load on an accepted forwarded beat, drop valid once the sink takes it
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         m_tdata_out  <= '0;
         m_tvalid_out <= 1'b0;
         m_tlast_out  <= 1'b0;
      end else if (state == S_XFER && acc) begin
         m_tdata_out  <= sel_data;
         m_tvalid_out <= 1'b1;
         m_tlast_out  <= sel_last | last_beat;
      end else if (m_tready_in) begin
         m_tvalid_out <= 1'b0;
      end
   end
   // packet FSM: arbitrate, forward, discard the tail of over-long packets, then hold the gap
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= S_IDLE;
         grant_out <= '0;
         ptr       <= '0;
         beat_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: if (|s_tvalid_in) begin
               grant_out <= rr_grant;
               beat_cnt  <= '0;
               state     <= S_XFER;
            end
            S_XFER: if (acc) begin
               if (sel_last) begin
                  ptr       <= nxt_ptr;
                  gap_cnt   <= '0;
                  grant_out <= (G_IFG == 0) ? '0 : grant_out;
                  state     <= DONE_ST;
               end else if (last_beat) begin
                  state <= S_DROP;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            S_DROP: if (acc && sel_last) begin
               ptr       <= nxt_ptr;
               gap_cnt   <= '0;
               grant_out <= (G_IFG == 0) ? '0 : grant_out;
               state     <= DONE_ST;
            end
            S_GAP: if (gap_cnt == GAP_LAST) begin
               grant_out <= '0;
               state     <= S_IDLE;
            end else begin
               gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   // saturating statistics: packets per port (truncated ones included) and truncations overall
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < G_N_PORTS; i++) pkt_cnt[i] <= '0;
         stat_trunc_cnt <= '0;
      end else begin
         for (int i = 0; i < G_N_PORTS; i++) if (pkt_inc && gidx == PTR_W'(i)) pkt_cnt[i] <= sat_inc(pkt_cnt[i]);
         if (pkt_inc && !sel_last) stat_trunc_cnt <= sat_inc(stat_trunc_cnt);
      end
   end
   for (genvar g = 0; g < G_N_PORTS; g++) begin : g_stat
      assign stat_pkt_cnt[g*STAT_W +: STAT_W] = pkt_cnt[g];
   end
endmodule

// File: tb/tb_stream_tx_arbiter.sv
// tb_stream_tx_arbiter: directed self-checking bench for the two-port stream arbiter
module tb_stream_tx_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] td [2];
   logic tv [2];
   logic tl [2];
   logic [15:0] s_tdata;
   logic [1:0] s_tvalid, s_tlast, s_tready, grant;
   logic [7:0] m_tdata;
   logic m_tvalid, m_tlast;
   logic m_tready = 1'b1;
   logic tog = 1'b0;
   logic abort = 1'b0;
   logic [31:0] stat_pkt;
   logic [15:0] stat_trunc;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc, acc_b, acc_c, acc_d;
   logic [10:0] rxq [$];
   int cycq [$];

   assign s_tdata = {td[1], td[0]};
   assign s_tvalid = {tv[1], tv[0]};
   assign s_tlast = {tl[1], tl[0]};

   stream_tx_arbiter #(.G_N_PORTS(2), .G_MAX_LEN(16), .G_IFG(2)) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .s_tdata_in     (s_tdata),
      .s_tvalid_in    (s_tvalid),
      .s_tlast_in     (s_tlast),
      .s_tready_out   (s_tready),
      .m_tdata_out    (m_tdata),
      .m_tvalid_out   (m_tvalid),
      .m_tlast_out    (m_tlast),
      .m_tready_in    (m_tready),
      .grant_out      (grant),
      .stat_pkt_cnt   (stat_pkt),
      .stat_trunc_cnt (stat_trunc)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      m_tready = tog ? ~m_tready : 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
         rxq.push_back({grant, m_tlast, m_tdata});
         cycq.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic src(input int p, input int n, input logic [7:0] base, output int cnt);
      int t = 0;
      cnt = 0;
      @(posedge clk);
      #1;
      while (cnt < n && !abort && t < 500) begin
         td[p] = base + 8'(cnt);
         tl[p] = (cnt == n - 1);
         tv[p] = 1'b1;
         @(negedge clk);
         if (s_tready[p]) cnt++;
         @(posedge clk);
         #1;
         t++;
      end
      tv[p] = 1'b0;
      tl[p] = 1'b0;
      if (t >= 500) check($sformatf("src%0d_timeout", p), cnt, n);
   endtask

   task automatic drain(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check_pkt(input string tag, input int start, input int n, input logic [7:0] base, input logic [1:0] g);
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", tag, i), (start + i < rxq.size()) ? 32'(rxq[start + i]) : 32'hDEAD,
               {21'd0, g, 1'(i == n - 1), 8'(base + 8'(i))});
   endtask

   task automatic clear_q();
      rxq.delete();
      cycq.delete();
   endtask

   initial begin
      td[0] = '0; td[1] = '0; tv[0] = 1'b0; tv[1] = 1'b0; tl[0] = 1'b0; tl[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_grant", grant, 0);
      check("rst_tready", s_tready, 0);
      check("rst_pkt", stat_pkt, 0);
      check("rst_trunc", stat_trunc, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single 10-beat packet on port 0
      src(0, 10, 8'h01, acc);
      drain(8);
      check("t1_len", rxq.size(), 10);
      check_pkt("t1", 0, 10, 8'h01, 2'b01);
      check("t1_pkt0", stat_pkt[15:0], 1);
      check("t1_idle_grant", grant, 0);
      check("t1_idle_tready", s_tready, 0);

      // both ports contending; pointer now favours port 1
      clear_q();
      fork
         begin src(0, 4, 8'h10, acc); src(0, 4, 8'h20, acc_b); end
         begin src(1, 4, 8'h80, acc_c); src(1, 4, 8'h90, acc_d); end
      join
      drain(10);
      check("t2_len", rxq.size(), 16);
      check_pkt("t2a", 0, 4, 8'h80, 2'b10);
      check_pkt("t2b", 4, 4, 8'h10, 2'b01);
      check_pkt("t2c", 8, 4, 8'h90, 2'b10);
      check_pkt("t2d", 12, 4, 8'h20, 2'b01);
      if (cycq.size() >= 16)
         for (int k = 4; k < 16; k += 4) check($sformatf("t2_gap%0d", k), 32'((cycq[k] - cycq[k-1]) >= 3), 1);
      check("t2_pkt0", stat_pkt[15:0], 3);
      check("t2_pkt1", stat_pkt[31:16], 2);

      // over-long packet on port 1 is cut at 16 beats
      clear_q();
      src(1, 20, 8'h40, acc);
      drain(8);
      check("t3_acc", acc, 20);
      check("t3_len", rxq.size(), 16);
      check_pkt("t3", 0, 16, 8'h40, 2'b10);
      check("t3_trunc", stat_trunc, 1);
      check("t3_pkt1", stat_pkt[31:16], 3);

      // exactly 16 beats with tlast on the last one is not a truncation
      clear_q();
      src(0, 16, 8'hA0, acc);
      drain(8);
      check("t4_len", rxq.size(), 16);
      check_pkt("t4", 0, 16, 8'hA0, 2'b01);
      check("t4_trunc", stat_trunc, 1);
      check("t4_pkt0", stat_pkt[15:0], 4);

      // downstream ready toggling every cycle
      clear_q();
      tog = 1'b1;
      src(1, 8, 8'hC0, acc);
      drain(8);
      tog = 1'b0;
      drain(2);
      check("t5_len", rxq.size(), 8);
      check_pkt("t5", 0, 8, 8'hC0, 2'b10);
      check("t5_pkt1", stat_pkt[31:16], 4);

      // asynchronous reset in the middle of a packet
      clear_q();
      fork
         src(0, 10, 8'h30, acc);
         begin
            for (int k = 0; k < 300 && rxq.size() < 4; k++) begin
               @(negedge clk);
               #1;
            end
            #1;
            rst_n = 1'b0;
            abort = 1'b1;
            #1;
            check("t6_tvalid", m_tvalid, 0);
            check("t6_tlast", m_tlast, 0);
            check("t6_tdata", m_tdata, 0);
            check("t6_grant", grant, 0);
            check("t6_tready", s_tready, 0);
            check("t6_pkt", stat_pkt, 0);
            check("t6_trunc", stat_trunc, 0);
         end
      join
      drain(3);
      check("t6_prelen", rxq.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t6_pre[%0d]", i), (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, {21'd0, 2'b01, 1'b0, 8'(8'h30 + 8'(i))});
      clear_q();
      @(negedge clk);
      rst_n = 1'b1;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      src(1, 5, 8'hE0, acc);
      drain(8);
      check("t6_len", rxq.size(), 5);
      check_pkt("t6", 0, 5, 8'hE0, 2'b10);
      check("t6_pkt1", stat_pkt[31:16], 1);
      check("t6_pkt0", stat_pkt[15:0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
